jtag_tap_ctrl: RTL
==================

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 Parameter IR_WIDTH, default 4, instruction register width; legal range 2..8.
REQ-002 Parameter NUM_CHAINS, default 3, number of data-register scan chains behind the TAP; legal range 1..(2^IR_WIDTH - 1).
REQ-003 clock  input  1  single clock; every rising edge is one TCK cycle.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 tms  input  1  test mode select, sampled on clock rising edge.
REQ-006 tdi  input  1  serial data in, sampled on clock rising edge.
REQ-007 chain_tdo  input  NUM_CHAINS  serial out of each chain; bit k = chain k.
REQ-008 tdo  output  1  registered serial data out.
REQ-009 tdo_en  output  1  high when tdo carries valid shift data.
REQ-010 chain_sel  output  NUM_CHAINS  one-hot chain select; all-zero when BYPASS active.
REQ-011 capture_dr, shift_dr, update_dr  output  1 each  high while TAP is in Capture-DR / Shift-DR / Update-DR.
REQ-012 ir_out  output  IR_WIDTH  current (updated) instruction.
REQ-013 tap_state  output  4  current TAP state encoding.

Function
REQ-014 TAP FSM SHALL implement the 16 IEEE 1149.1 states and TMS-driven transitions exactly: TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR.
REQ-015 Five consecutive cycles with tms=1 SHALL reach TLR from any state.
REQ-016 IR shift register: in CAP_IR loads IR_WIDTH'b...01 (bit0=1, bit1=0, rest 0); in SHIFT_IR shifts right, tdi into MSB, bit0 leaves toward tdo.
REQ-017 ir_out SHALL load from IR shift register on the edge leaving UPD_IR (i.e. while state==UPD_IR); ir_out unchanged in all other states.
REQ-018 Decode: ir_out = k with k < NUM_CHAINS selects chain k; any other value (incl. all-ones) selects BYPASS.
REQ-019 Bypass register (1 bit): cleared in CAP_DR when BYPASS selected; in SHIFT_DR loads tdi.
REQ-020 tdo SHALL update one cycle after the shifting edge: in SHIFT_IR tdo <= IR shift bit0; in SHIFT_DR tdo <= bypass register (BYPASS) or chain_tdo[k]; otherwise tdo holds.
REQ-021 tdo_en <= 1 on edges where state is SHIFT_IR or SHIFT_DR, else 0.
REQ-022 capture_dr/shift_dr/update_dr are combinational decodes of the state register, independent of chain selection; chain_sel gates them downstream.
REQ-023 PAUSE states SHALL hold all shift-register contents and tdo.
REQ-024 Entering TLR via tms (not reset) SHALL also force ir_out to all-ones (BYPASS).

Reset
REQ-025 reset_n=0 at a clock edge SHALL force: state TLR, ir_out all-ones, IR shift reg all-ones, bypass reg 0, tdo 0, tdo_en 0; chain_sel therefore 0.
REQ-026 Reset mid-shift SHALL discard partial IR/DR contents; no UPD pulse is generated.

Structure
REQ-027 Shared package jtag_pkg SHALL hold the 4-bit state encodings and the BYPASS opcode constant.
REQ-028 The 16-state FSM SHALL be a sub-module jtag_tap_fsm (clock, reset_n, tms -> tap_state); IR, bypass, decode and tdo mux stay in jtag_tap_ctrl.

Verification
REQ-029 Reset, tms=0 for 3 cycles -> state RTI, ir_out=4'b1111, chain_sel=3'b000, tdo_en=0.
REQ-030 From RTI, tms 1,1,0,0 -> SHIFT_IR; shift tdi=0,1,0,0 (last with tms=1), tms 1,0 -> ir_out=4'b0010, chain_sel=3'b100; tdo bits observed = 1,0,0,0 (captured 0001).
REQ-031 Chain 1 selected, in SHIFT_DR drive chain_tdo[1] pattern 1,0,1,1 -> tdo shows 1,0,1,1 each one cycle later, tdo_en=1 throughout, shift_dr high.
REQ-032 BYPASS selected, shift tdi=1,0,1 for 3 cycles in SHIFT_DR -> tdo = 0 (captured), 1, 0: one-bit delay.
REQ-033 Any state, tms=1 for 5 cycles -> state TLR, ir_out=4'b1111; reset_n=0 during SHIFT_DR -> next cycle TLR, tdo=0, no update_dr pulse.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP controller: TAP state encodings
// and the instruction-register constants used by the controller.
package jtag_pkg;

    // Standard 4-bit TAP state encodings as seen on tap_state.
    typedef enum logic [3:0] {
        EXIT2_DR = 4'h0,
        EXIT1_DR = 4'h1,
        SHIFT_DR = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EXIT2_IR = 4'h8,
        EXIT1_IR = 4'h9,
        SHIFT_IR = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_e;

    // Widest supported instruction register.
    localparam int IR_WIDTH_MAX = 8;

    // BYPASS is the all-ones opcode; slice to the actual IR width.
    localparam logic [IR_WIDTH_MAX-1:0] BYPASS_OPCODE = '1;

    // Value loaded into the IR shift register in Capture-IR (bit0=1, bit1=0).
    localparam logic [IR_WIDTH_MAX-1:0] IR_CAPTURE_PATTERN = 8'h01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine driven by TMS.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tms,
    output logic [3:0] tap_state
);

    tap_state_e state_q;
    tap_state_e state_d;

    // State register with synchronous active-low reset to Test-Logic-Reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: TMS-driven transitions of the TAP graph.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_d = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_d = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_d = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_d = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Output: expose the registered state encoding.
    always_comb begin
        tap_state = state_q;
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: TAP FSM plus instruction register, bypass register,
// chain decode and the registered TDO mux.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH   = 4,
    parameter int NUM_CHAINS = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  tms,
    input  logic                  tdi,
    input  logic [NUM_CHAINS-1:0] chain_tdo,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [NUM_CHAINS-1:0] chain_sel,
    output logic                  capture_dr,
    output logic                  shift_dr,
    output logic                  update_dr,
    output logic [IR_WIDTH-1:0]   ir_out,
    output logic [3:0]            tap_state
);

    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = BYPASS_OPCODE[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_CAPTURE_PATTERN[IR_WIDTH-1:0];

    tap_state_e state;

    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_out_q,   ir_out_d;
    logic                bypass_q,   bypass_d;
    logic                tdo_q,      tdo_d;
    logic                tdo_en_q,   tdo_en_d;
    logic                bypass_sel;
    logic                chain_bit;
    logic                enter_tlr;

    jtag_tap_fsm u_fsm (
        .clock     (clock),
        .reset_n   (reset_n),
        .tms       (tms),
        .tap_state (tap_state)
    );

    assign state = tap_state_e'(tap_state);

    // One-hot chain decode of the current instruction; no match means BYPASS.
    always_comb begin
        chain_sel = '0;
        for (int k = 0; k < NUM_CHAINS; k++) begin
            chain_sel[k] = (ir_out_q == IR_WIDTH'(k));
        end
    end

    assign bypass_sel = ~|chain_sel;
    assign chain_bit  = |(chain_tdo & chain_sel);

    // The only TMS path into TLR is from Select-IR (or staying in TLR), so
    // the instruction can be forced to BYPASS on the same edge TLR is reached.
    assign enter_tlr = (state == TLR) || ((state == SEL_IR) && tms);

    // Next values for the IR, bypass register and TDO pipeline.
    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_out_d   = ir_out_q;
        bypass_d   = bypass_q;
        tdo_d      = tdo_q;
        tdo_en_d   = (state == SHIFT_IR) || (state == SHIFT_DR);

        if (state == CAP_IR) begin
            ir_shift_d = IR_CAPTURE;
        end else if (state == SHIFT_IR) begin
            ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
            tdo_d      = ir_shift_q[0];
        end

        if (state == CAP_DR && bypass_sel) begin
            bypass_d = 1'b0;
        end else if (state == SHIFT_DR) begin
            bypass_d = tdi;
            tdo_d    = bypass_sel ? bypass_q : chain_bit;
        end

        if (state == UPD_IR) begin
            ir_out_d = ir_shift_q;
        end else if (enter_tlr) begin
            ir_out_d = IR_BYPASS;
        end
    end

    // Registers with synchronous active-low reset; reset drops any partial shift.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ir_shift_q <= '1;
            ir_out_q   <= IR_BYPASS;
            bypass_q   <= 1'b0;
            tdo_q      <= 1'b0;
            tdo_en_q   <= 1'b0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_out_q   <= ir_out_d;
            bypass_q   <= bypass_d;
            tdo_q      <= tdo_d;
            tdo_en_q   <= tdo_en_d;
        end
    end

    // Data-register strobes decoded straight from the state register.
    always_comb begin
        capture_dr = (state == CAP_DR);
        shift_dr   = (state == SHIFT_DR);
        update_dr  = (state == UPD_DR);
    end

    assign tdo    = tdo_q;
    assign tdo_en = tdo_en_q;
    assign ir_out = ir_out_q;

endmodule
